// File: rtl/out_byte_uart_pkg.sv
`default_nettype none
// ============================================================================
// out_byte_uart_pkg : FSM state type, frame constants and parity helper for
// the byte-port UART transmitter. Optional parity: OUT_BYTE_UART_PARITY_EN.
// Revision: 1.0
// ============================================================================
package out_byte_uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef OUT_BYTE_UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int FRAME_BITS = 11;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } uart_state_t;

    localparam int FRAME_BITS = 10;
`endif

endpackage
`default_nettype wire

// File: rtl/out_byte_fifo.sv
`default_nettype none
// ============================================================================
// out_byte_fifo : byte FIFO with combinational head, exact occupancy count.
// Revision: 1.0
// ============================================================================
module out_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               push_data,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/out_byte_uart_tx.sv
`default_nettype none
// ============================================================================
// out_byte_uart_tx : CPU output-port bytes -> FIFO -> 8N1 serial line.
// Optional even parity bit with macro OUT_BYTE_UART_PARITY_EN.  Revision: 1.0
// ============================================================================
module out_byte_uart_tx
    import out_byte_uart_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_byte,
    input  logic                          in_byte_en,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

    uart_state_t state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  head;
    logic        fifo_empty;
    logic        bit_done;
    logic        pop;
`ifdef OUT_BYTE_UART_PARITY_EN
    logic        parity_bit;
`endif

    assign bit_done = (bit_cnt == '0);
    // Head leaves the FIFO when idle, or when a stop bit ends (back-to-back).
    assign pop  = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
    assign busy = (state != ST_IDLE) || !fifo_empty;

    out_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_byte_en),
        .pop       (pop),
        .push_data (in_byte),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            overflow   <= 1'b0;
`ifdef OUT_BYTE_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (in_byte_en && fifo_full && !pop) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg      <= head;
`ifdef OUT_BYTE_UART_PARITY_EN
                        parity_bit <= even_parity(head);
`endif
                        state      <= ST_START;
                        tx         <= 1'b0;
                        bit_cnt    <= BIT_RELOAD;
                    end
                end

                ST_START: begin
                    if (!bit_done) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        bit_cnt <= BIT_RELOAD;
                    end
                end

                ST_DATA: begin
                    if (!bit_done) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef OUT_BYTE_UART_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity_bit;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                end

`ifdef OUT_BYTE_UART_PARITY_EN
                ST_PARITY: begin
                    if (!bit_done) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else begin
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= BIT_RELOAD;
                    end
                end
`endif

                ST_STOP: begin
                    if (!bit_done) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else if (pop) begin
                        shreg      <= head;
`ifdef OUT_BYTE_UART_PARITY_EN
                        parity_bit <= even_parity(head);
`endif
                        state      <= ST_START;
                        tx         <= 1'b0;
                        bit_cnt    <= BIT_RELOAD;
                    end else begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/out_byte_uart_tx.md
OUT_BYTE_UART_TX -- requirements
Module: out_byte_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO entries; power of two, 2..64.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port in_byte, input, 8 bits: byte from CPU output port.
REQ-007 SHALL have port in_byte_en, input, 1 bit: one-cycle strobe qualifying in_byte.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high when FSM not IDLE or FIFO non-empty.
REQ-010 SHALL have port fifo_full, output, 1 bit: FIFO count equals FIFO_DEPTH.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a dropped byte.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

Function
REQ-013 SHALL push in_byte into the FIFO on a clock edge where in_byte_en=1 and (count<FIFO_DEPTH or a pop occurs on the same edge).
REQ-014 SHALL drop in_byte and set overflow=1 when in_byte_en=1, FIFO full, and no pop on that edge; overflow clears only on reset.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-027.
REQ-016 SHALL, in IDLE with FIFO non-empty, pop the head byte into a shift register and enter START on the same edge.
REQ-017 SHALL drive tx registered: 1 in IDLE and STOP, 0 in START, shift-register bit 0 in DATA (LSB first).
REQ-018 SHALL hold each bit for exactly CLK_DIV cycles using a bit-period counter reloaded on every state or bit change.
REQ-019 SHALL send 8 DATA bits counted by a 3-bit index, then advance to PARITY or STOP.
REQ-020 SHALL, at the end of STOP with FIFO non-empty, pop and enter START directly (no idle cycle); otherwise enter IDLE.
REQ-021 SHALL produce a first tx falling edge 2 cycles after the in_byte_en cycle when idle and empty (push edge N, pop/START edge N+1).
REQ-022 SHALL keep fifo_count exact under simultaneous push and pop (unchanged value).
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-024 SHALL, on reset assertion, immediately force tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0, FSM=IDLE, pointers and counters to 0, irrespective of clock.
REQ-025 SHALL abort any frame in progress on reset; discarded bytes are not retransmitted.
REQ-026 SHALL ignore in_byte_en while reset is high.

Configuration
REQ-027 SHALL, with macro OUT_BYTE_UART_PARITY_EN defined, insert a PARITY bit of even parity (XOR of the 8 data bits) for CLK_DIV cycles between DATA and STOP; frame 11 bits.
REQ-028 SHALL, without OUT_BYTE_UART_PARITY_EN, omit the PARITY state and logic entirely; frame 10 bits.

Structure
REQ-029 SHALL place the FSM state enum, frame-length constants and the parity function in package out_byte_uart_pkg.
REQ-030 SHALL implement the FIFO as sub-module out_byte_fifo (push, pop, data, count, full, empty), instantiated once.

Verification
REQ-031 SHALL cover: CLK_DIV=4, no parity, one strobe 0x41 -> tx low 2 cycles later, then 4-cycle bits 0,1,0,0,0,0,0,1,0,1, then idle high, busy low.
REQ-032 SHALL cover: OUT_BYTE_UART_PARITY_EN, 0x41 -> parity bit 0; 0x43 -> parity bit 1; 11-bit frames, 44 cycles each.
REQ-033 SHALL cover: FIFO_DEPTH=4, 6 strobes on consecutive cycles from idle -> 5 accepted, 6th dropped, overflow=1, 5 frames transmitted back-to-back with no gap cycles.
REQ-034 SHALL cover: push and pop on same edge with FIFO full -> byte accepted, fifo_count stays 4, overflow stays 0.
REQ-035 SHALL cover: reset asserted mid DATA bit 3 -> tx=1 and fifo_count=0 without waiting for a clock edge; next strobe after release sends a clean frame.
REQ-036 SHALL cover: 20 random bytes at random spacing with CLK_DIV=2 -> serial decoder model recovers identical sequence while overflow stays 0.
